alu: RTL and testbench
======================

// Module: alu
//
// PURPOSE
// 8-bit arithmetic/logic unit for the basic processor datapath; sits between
// the register file read ports and the writeback mux. Result and Zero are
// combinational from the operands and opcode. The shift/carry-out bit is
// registered on Clk and feeds the next instruction's SC_in.
//
// PARAMETERS
// (none) - data width fixed at 8, opcode width fixed at 3
//
// PORTS
// Clk     input   1  system clock, rising edge
// Reset   input   1  asynchronous, active-high; clears SC_out
// InputA  input   8  operand A
// InputB  input   8  operand B
// SC_in   input   1  shift/carry in
// OP      input   3  opcode
// Out     output  8  result, combinational
// Zero    output  1  1 when Out == 8'h00, combinational
// SC_out  output  1  registered shift/carry out
//
// BEHAVIOUR
// - Out is settled within the same cycle as input changes; no latency, no handshake.
// - Opcodes:
//   - 000 ADD: Out = A + B + SC_in (mod 256); c = bit 8 of the 9-bit sum
//   - 001 LSL: Out = {A[6:0], SC_in}; c = A[7]
//   - 010 LSR: Out = {SC_in, A[7:1]}; c = A[0]
//   - 011 XOR: Out = A ^ B; c = 0
//   - 100 SNE: Out = (A != B) ? 8'h01 : 8'h00; c = 0
//   - 101 SEQ: Out = (A == B) ? 8'h01 : 8'h00; c = 0
//   - 110 MSK: Out = A & (8'h01 << B[2:0]); B[7:3] ignored; c = 0
//   - 111: see CONFIGURATION
// - Zero = ~|Out for every opcode, including 111.
// - SC_out: flop loaded with c on every rising Clk edge; no enable.
// - Reset: SC_out = 0 immediately on assertion and held while Reset = 1.
//   Out and Zero are unaffected by Reset (purely combinational).
// - Wrap-around: ADD 8'hFF + 8'h01 + 0 gives Out = 8'h00, Zero = 1, c = 1.
// - Unknown or X opcode: Out = 8'h00, c = 0 (default branch, no latches).
//
// CONFIGURATION
// ALU_SUB_EN defined: OP 111 = SUB.
//   - Out = A + ~B + 1 (mod 256)
//   - c = 1 when there is no borrow (A >= B unsigned)
// ALU_SUB_EN undefined: OP 111 gives Out = 8'h00, Zero = 1, c = 0.
//
// TESTING
// - ADD A=1, B=1, SC_in=0 -> Out=2, Zero=0; after next Clk edge SC_out=0.
// - LSL A=4, SC_in=0 -> Out=8. LSR A=4, SC_in=0 -> Out=2.
//   LSR A=8'h81, SC_in=1 -> Out=8'hC0; after Clk edge SC_out=1.
// - XOR A=2, B=6 -> Out=4. SNE A=0, B=1 -> Out=1.
//   SEQ A=5, B=5 -> Out=1. SEQ A=5, B=4 -> Out=0, Zero=1.
// - MSK A=7, B=2 -> Out=4. MSK A=7, B=3 -> Out=0, Zero=1.
// - ADD A=8'hFF, B=1 -> Out=0, Zero=1; Clk edge gives SC_out=1.
//   Assert Reset between edges -> SC_out=0 at once, without waiting for Clk.
// - OP=111, A=5, B=3:
//   with ALU_SUB_EN -> Out=2, SC_out=1 after the Clk edge;
//   without ALU_SUB_EN -> Out=0, Zero=1.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between the register file read ports, the ALU and the writeback mux.
// The testbench or datapath holds the master side; the ALU is the slave.
interface alu_if;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       SC_in;
    logic [2:0] OP;
    logic [7:0] Out;
    logic       Zero;
    logic       SC_out;

    modport master (
        output InputA, InputB, SC_in, OP,
        input  Out, Zero, SC_out
    );

    modport slave (
        input  InputA, InputB, SC_in, OP,
        output Out, Zero, SC_out
    );
endinterface

// File: rtl/alu.sv
// 8-bit datapath ALU: combinational result/zero, registered shift/carry out.
// Define ALU_SUB_EN to turn opcode 111 into SUB; otherwise 111 yields zero.
module alu (
    input  logic   Clk,
    input  logic   Reset,
    alu_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_LSL = 3'b001,
        OP_LSR = 3'b010,
        OP_XOR = 3'b011,
        OP_SNE = 3'b100,
        OP_SEQ = 3'b101,
        OP_MSK = 3'b110,
        OP_EXT = 3'b111
    } op_e;

    op_e        op;
    logic [7:0] out_c;
    logic [8:0] sum;
    logic       sc_out_d;
    logic       sc_out_q;

    assign op = op_e'(bus.OP);

    always_comb begin
        out_c    = '0;
        sc_out_d = 1'b0;
        sum      = '0;
        case (op)
            OP_ADD: begin
                sum      = {1'b0, bus.InputA} + {1'b0, bus.InputB} + {8'b0, bus.SC_in};
                out_c    = sum[7:0];
                sc_out_d = sum[8];
            end
            OP_LSL: begin
                out_c    = {bus.InputA[6:0], bus.SC_in};
                sc_out_d = bus.InputA[7];
            end
            OP_LSR: begin
                out_c    = {bus.SC_in, bus.InputA[7:1]};
                sc_out_d = bus.InputA[0];
            end
            OP_XOR: out_c = bus.InputA ^ bus.InputB;
            OP_SNE: out_c = {7'b0, bus.InputA != bus.InputB};
            OP_SEQ: out_c = {7'b0, bus.InputA == bus.InputB};
            OP_MSK: out_c = bus.InputA & (8'h01 << bus.InputB[2:0]);
            OP_EXT: begin
`ifdef ALU_SUB_EN
                // Carry out of A + ~B + 1 is the "no borrow" flag.
                sum      = {1'b0, bus.InputA} + {1'b0, ~bus.InputB} + 9'd1;
                out_c    = sum[7:0];
                sc_out_d = sum[8];
`else
                out_c    = '0;
                sc_out_d = 1'b0;
`endif
            end
            default: begin
                out_c    = '0;
                sc_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) sc_out_q <= 1'b0;
        else       sc_out_q <= sc_out_d;
    end

    assign bus.Out    = out_c;
    assign bus.Zero   = ~|out_c;
    assign bus.SC_out = sc_out_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations plus
// an arithmetic reference model checked on every falling clock edge.
module tb_alu;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic exp_sc;
    bit   running;

    alu_if bus ();

    alu dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic sc,
                                  output logic [7:0] o, output logic c);
        int ia, ib, isc, s, sh;
        ia  = int'(a);
        ib  = int'(b);
        isc = int'(sc);
        o   = 8'h00;
        c   = 1'b0;
        case (op)
            3'd0: begin s = ia + ib + isc; o = 8'(s % 256); c = (s >= 256); end
            3'd1: begin o = 8'((ia * 2 + isc) % 256); c = (ia >= 128); end
            3'd2: begin o = 8'(ia / 2 + isc * 128); c = (ia % 2 == 1); end
            3'd3: o = a ^ b;
            3'd4: o = (ia != ib) ? 8'd1 : 8'd0;
            3'd5: o = (ia == ib) ? 8'd1 : 8'd0;
            3'd6: begin
                sh = ib % 8;
                o  = (((ia >> sh) % 2) == 1) ? 8'(1 << sh) : 8'd0;
            end
            3'd7: begin
`ifdef ALU_SUB_EN
                s = ia - ib;
                o = 8'((s + 256) % 256);
                c = (ia >= ib);
`else
                o = 8'h00;
                c = 1'b0;
`endif
            end
            default: ;
        endcase
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Expected SC_out: loaded from the model's carry at each edge, cleared by reset.
    always @(posedge clk or posedge rst) begin
        logic [7:0] o;
        logic       c;
        if (rst) exp_sc <= 1'b0;
        else begin
            model(bus.OP, bus.InputA, bus.InputB, bus.SC_in, o, c);
            exp_sc <= c;
        end
    end

    always @(negedge clk) begin
        logic [7:0] o;
        logic       c;
        if (running) begin
            model(bus.OP, bus.InputA, bus.InputB, bus.SC_in, o, c);
            check8("model_out", bus.Out, o);
            check1("model_zero", bus.Zero, (o == 8'h00));
            check1("model_sc_out", bus.SC_out, exp_sc);
        end
    end

    // Drive at posedge+1, check result at +3, check SC_out after the next edge.
    task automatic run_vec(input string name, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic sc, input logic [7:0] exp_out,
                           input logic exp_zero, input bit chk_c, input logic exp_c);
        bus.OP     = op;
        bus.InputA = a;
        bus.InputB = b;
        bus.SC_in  = sc;
        #2;
        check8({name, "_out"}, bus.Out, exp_out);
        check1({name, "_zero"}, bus.Zero, exp_zero);
        @(posedge clk);
        #1;
        if (chk_c) check1({name, "_sc"}, bus.SC_out, exp_c);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        running    = 1'b0;
        rst        = 1'b1;
        bus.OP     = 3'd0;
        bus.InputA = 8'h00;
        bus.InputB = 8'h00;
        bus.SC_in  = 1'b0;
        #1;
        check1("reset_sc_out", bus.SC_out, 1'b0);
        @(posedge clk);
        #1;
        check1("reset_held_sc_out", bus.SC_out, 1'b0);
        rst     = 1'b0;
        running = 1'b1;

        run_vec("add_1_1",   3'd0, 8'd1,   8'd1,   1'b0, 8'd2,   1'b0, 1, 1'b0);
        run_vec("lsl_4",     3'd1, 8'd4,   8'd0,   1'b0, 8'd8,   1'b0, 1, 1'b0);
        run_vec("lsr_4",     3'd2, 8'd4,   8'd0,   1'b0, 8'd2,   1'b0, 1, 1'b0);
        run_vec("lsr_81",    3'd2, 8'h81,  8'd0,   1'b1, 8'hC0,  1'b0, 1, 1'b1);
        run_vec("lsl_80",    3'd1, 8'h80,  8'd0,   1'b1, 8'h01,  1'b0, 1, 1'b1);
        run_vec("xor_2_6",   3'd3, 8'd2,   8'd6,   1'b1, 8'd4,   1'b0, 1, 1'b0);
        run_vec("sne_0_1",   3'd4, 8'd0,   8'd1,   1'b0, 8'd1,   1'b0, 1, 1'b0);
        run_vec("seq_5_5",   3'd5, 8'd5,   8'd5,   1'b0, 8'd1,   1'b0, 1, 1'b0);
        run_vec("seq_5_4",   3'd5, 8'd5,   8'd4,   1'b0, 8'd0,   1'b1, 1, 1'b0);
        run_vec("msk_7_2",   3'd6, 8'd7,   8'd2,   1'b0, 8'd4,   1'b0, 1, 1'b0);
        run_vec("msk_7_3",   3'd6, 8'd7,   8'd3,   1'b0, 8'd0,   1'b1, 1, 1'b0);
        run_vec("msk_hi_b",  3'd6, 8'hF0,  8'hFC,  1'b0, 8'h10,  1'b0, 1, 1'b0);
        run_vec("add_7f_80", 3'd0, 8'h7F,  8'h80,  1'b1, 8'h00,  1'b1, 1, 1'b1);
        run_vec("add_ff_1",  3'd0, 8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1, 1'b1);

        // Asynchronous reset between edges clears SC_out without a clock.
        #2;
        rst = 1'b1;
        #1;
        check1("async_reset_sc_out", bus.SC_out, 1'b0);
        check8("reset_keeps_out", bus.Out, 8'h00);
        @(posedge clk);
        #1;
        check1("reset_hold_edge", bus.SC_out, 1'b0);
        rst = 1'b0;
        #1;

`ifdef ALU_SUB_EN
        run_vec("sub_5_3",   3'd7, 8'd5,   8'd3,   1'b0, 8'd2,   1'b0, 1, 1'b1);
        run_vec("sub_3_5",   3'd7, 8'd3,   8'd5,   1'b0, 8'hFE,  1'b0, 1, 1'b0);
        run_vec("sub_9_9",   3'd7, 8'd9,   8'd9,   1'b1, 8'h00,  1'b1, 1, 1'b1);
`else
        run_vec("op7_5_3",   3'd7, 8'd5,   8'd3,   1'b0, 8'd0,   1'b1, 1, 1'b0);
        run_vec("op7_ff_0",  3'd7, 8'hFF,  8'h00,  1'b1, 8'd0,   1'b1, 1, 1'b0);
`endif

        // Sweep every opcode with varied operands against the model.
        for (int i = 0; i < 64; i++) begin
            bus.OP     = 3'(i % 8);
            bus.InputA = 8'($urandom_range(0, 255));
            bus.InputB = (i % 5 == 0) ? bus.InputA : 8'($urandom_range(0, 255));
            bus.SC_in  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
